// File: rtl/k12a_pkg.sv
// Shared k12a definitions: SRAM sequencer state encoding and counter width.
package k12a_pkg;

    localparam int unsigned SRAM_CNT_W = 4;

    typedef enum logic [2:0] {
        SRAM_IDLE,
        SRAM_W_SETUP,
        SRAM_W_PULSE,
        SRAM_W_HOLD,
        SRAM_READ
    } sram_state_t;

endpackage

// File: rtl/k12a_sram_ctl.sv
// Turns single-cycle CPU memory requests into phased asynchronous SRAM cycles
// with registered, glitch-free ce_n/oe_n/we_n strobes.
module k12a_sram_ctl
    import k12a_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned READ_WAIT   = 1,
    parameter int unsigned WRITE_PULSE = 1
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam logic [SRAM_CNT_W-1:0] READ_LOAD  = SRAM_CNT_W'(READ_WAIT);
    localparam logic [SRAM_CNT_W-1:0] PULSE_LOAD = SRAM_CNT_W'(WRITE_PULSE - 1);

    sram_state_t           state;
    sram_state_t           next_state;
    logic [SRAM_CNT_W-1:0] cnt;
    logic                  ce_n_d;
    logic                  oe_n_d;
    logic                  we_n_d;
    logic                  dq_oe_d;

    assign req_ready = (state == SRAM_IDLE) && !reset;

    // Strobes are registered from next_state so each pin changes exactly on
    // the edge that enters the corresponding state.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state      <= SRAM_IDLE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            state      <= next_state;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_dq_oe <= dq_oe_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SRAM_IDLE:    if (req_valid) next_state = req_write ? SRAM_W_SETUP : SRAM_READ;
            SRAM_W_SETUP: next_state = SRAM_W_PULSE;
            SRAM_W_PULSE: if (cnt == '0) next_state = SRAM_W_HOLD;
            SRAM_W_HOLD:  next_state = SRAM_IDLE;
            SRAM_READ:    if (cnt == '0) next_state = SRAM_IDLE;
            default:      next_state = SRAM_IDLE;
        endcase
    end

    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (next_state)
            SRAM_W_SETUP, SRAM_W_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            SRAM_W_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            SRAM_READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                SRAM_IDLE: begin
                    if (req_valid) begin
                        sram_addr <= req_addr;
                        if (req_write) sram_dq_out <= req_wdata;
                        else           cnt         <= READ_LOAD;
                    end
                end
                SRAM_W_SETUP: cnt <= PULSE_LOAD;
                SRAM_W_PULSE: if (cnt != '0) cnt <= cnt - 1'b1;
                SRAM_W_HOLD:  rsp_valid <= 1'b1;
                SRAM_READ: begin
                    if (cnt == '0) begin
                        rsp_rdata <= sram_dq_in;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_k12a_sram_ctl.sv
// Directed and random checks of k12a_sram_ctl against an asynchronous SRAM model,
// with a second instance for a non-default timing configuration.
module tb_k12a_sram_ctl;

    logic        sys_clock = 1'b0;
    logic        reset;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic        p_valid = 1'b0, p_write = 1'b0;
    logic [15:0] p_addr = '0;
    logic [7:0]  p_wdata = '0;
    logic        p_ready, p_rsp_valid;
    logic [7:0]  p_rdata;
    logic [15:0] p_sram_addr;
    logic [7:0]  p_dq_out, p_dq_in;
    logic        p_dq_oe, p_ce_n, p_oe_n, p_we_n;

    int n_cmp = 0;
    int n_err = 0;
    int n_viol = 0;

    logic [7:0] mem [0:65535];
    bit         written [0:65535];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    k12a_sram_ctl dut (
        .sys_clock(sys_clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    k12a_sram_ctl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_WAIT(0), .WRITE_PULSE(4)) dut_sw (
        .sys_clock(sys_clock), .reset(reset),
        .req_valid(p_valid), .req_ready(p_ready), .req_write(p_write),
        .req_addr(p_addr), .req_wdata(p_wdata),
        .rsp_valid(p_rsp_valid), .rsp_rdata(p_rdata),
        .sram_addr(p_sram_addr), .sram_dq_out(p_dq_out), .sram_dq_oe(p_dq_oe),
        .sram_dq_in(p_dq_in),
        .sram_ce_n(p_ce_n), .sram_oe_n(p_oe_n), .sram_we_n(p_we_n)
    );

    always #5 sys_clock = ~sys_clock;

    // SRAM model: write lands on the rising edge of we_n.
    always @(posedge sram_we_n) begin
        if (!reset) begin
            mem[sram_addr]     <= sram_dq_out;
            written[sram_addr] <= 1'b1;
        end
    end
    assign sram_dq_in = written[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
    assign p_dq_in    = init_val(p_sram_addr);

    always @(negedge sys_clock) begin
        if (!reset) begin
            if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n)) n_viol++;
            if ((!p_we_n && !p_oe_n) || (p_dq_oe && !p_oe_n)) n_viol++;
        end
    end

    task automatic tick;
        @(posedge sys_clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            n_err++; $display("FAIL reset_strobes: got %b want %b", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        end
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_rdata, sram_addr, sram_dq_out} !== 34'h0) begin
            n_err++; $display("FAIL reset_regs: got %h want %h", {req_ready, rsp_valid, rsp_rdata, sram_addr, sram_dq_out}, 34'h0);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b want %b", req_ready, 1'b1);
        end
    endtask

    task automatic test_single_write;
        logic [3:0] exp_s [0:3];
        exp_s = '{4'b0111, 4'b0101, 4'b0111, 4'b1110};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            n_cmp++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== exp_s[i]) begin
                n_err++; $display("FAIL write_strobes[%0d]: got %b want %b", i, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, exp_s[i]);
            end
            n_cmp++;
            if ({rsp_valid, sram_addr, sram_dq_out} !== {(i == 3), 16'h1234, 8'hA5}) begin
                n_err++; $display("FAIL write_rsp_bus[%0d]: got %h want %h", i, {rsp_valid, sram_addr, sram_dq_out}, {(i == 3), 16'h1234, 8'hA5});
            end
        end
        n_cmp++;
        if (mem[16'h1234] !== 8'hA5) begin
            n_err++; $display("FAIL write_landed: got %h want %h", mem[16'h1234], 8'hA5);
        end
    endtask

    task automatic test_single_read;
        logic [3:0] exp_s [0:2];
        exp_s = '{4'b0010, 4'b0010, 4'b1110};
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h00FF;
        tick();
        req_valid = 1'b0; req_addr = '0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            n_cmp++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== exp_s[i]) begin
                n_err++; $display("FAIL read_strobes[%0d]: got %b want %b", i, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, exp_s[i]);
            end
            n_cmp++;
            if (rsp_valid !== (i == 2)) begin
                n_err++; $display("FAIL read_rsp_valid[%0d]: got %b want %b", i, rsp_valid, (i == 2));
            end
        end
        n_cmp++;
        if (rsp_rdata !== 8'h3C) begin
            n_err++; $display("FAIL read_data: got %h want %h", rsp_rdata, 8'h3C);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h3C}) begin
            n_err++; $display("FAIL read_data_held: got %h want %h", {rsp_valid, rsp_rdata}, {1'b0, 8'h3C});
        end
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 8'h5A;
        tick();
        req_write = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b11) begin
            n_err++; $display("FAIL b2b_write_done: got %b want %b", {rsp_valid, req_ready}, 2'b11);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, req_ready} !== 5'b00100) begin
            n_err++; $display("FAIL b2b_read_start: got %b want %b", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, req_ready}, 5'b00100);
        end
        tick(); tick();
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h5A}) begin
            n_err++; $display("FAIL b2b_read_data: got %h want %h", {rsp_valid, rsp_rdata}, {1'b1, 8'h5A});
        end
    endtask

    task automatic test_backpressure;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0100; req_wdata = 8'h11;
        tick();
        req_addr = 16'h0200; req_wdata = 8'h22;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            if (i == 2) req_addr = 16'h0300;
            n_cmp++;
            if ({req_ready, sram_addr, sram_dq_out} !== {1'b0, 16'h0100, 8'h11}) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {req_ready, sram_addr, sram_dq_out}, {1'b0, 16'h0100, 8'h11});
            end
        end
        tick();
        n_cmp++;
        if ({rsp_valid, req_ready, sram_addr} !== {2'b11, 16'h0100}) begin
            n_err++; $display("FAIL bp_done: got %h want %h", {rsp_valid, req_ready, sram_addr}, {2'b11, 16'h0100});
        end
        req_valid = 1'b0; req_write = 1'b0;
        tick();
        n_cmp++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            n_err++; $display("FAIL bp_idle: got %b want %b", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        end
    endtask

    task automatic test_reset_mid_write;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0400; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        tick();
        n_cmp++;
        if (sram_we_n !== 1'b0) begin
            n_err++; $display("FAIL rst_pre_pulse: got %b want %b", sram_we_n, 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({sram_ce_n, sram_we_n, sram_dq_oe, req_ready} !== 4'b1100) begin
            n_err++; $display("FAIL rst_async: got %b want %b", {sram_ce_n, sram_we_n, sram_dq_oe, req_ready}, 4'b1100);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, req_ready} !== 2'b00) begin
                n_err++; $display("FAIL rst_held[%0d]: got %b want %b", i, {rsp_valid, req_ready}, 2'b00);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            n_cmp++;
            if ({rsp_valid, req_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 6'b011110) begin
                n_err++; $display("FAIL rst_after[%0d]: got %b want %b", i, {rsp_valid, req_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 6'b011110);
            end
        end
    endtask

    task automatic test_param_sweep;
        int  n;
        int  lowc;
        bit  done;
        p_valid = 1'b1; p_write = 1'b1; p_addr = 16'h0020; p_wdata = 8'h9C;
        tick();
        p_valid = 1'b0; p_write = 1'b0;
        n = 0; lowc = 0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            n++;
            if (p_we_n === 1'b0) lowc++;
            if (p_rsp_valid === 1'b1) done = 1'b1;
        end
        n_cmp++;
        if (n != 6) begin
            n_err++; $display("FAIL sweep_write_latency: got %0d want %0d", n, 6);
        end
        n_cmp++;
        if (lowc != 4) begin
            n_err++; $display("FAIL sweep_we_low_cycles: got %0d want %0d", lowc, 4);
        end
        p_valid = 1'b1; p_addr = 16'h0033;
        tick();
        p_valid = 1'b0;
        n = 0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            n++;
            if (p_rsp_valid === 1'b1) done = 1'b1;
        end
        n_cmp++;
        if (n != 1) begin
            n_err++; $display("FAIL sweep_read_latency: got %0d want %0d", n, 1);
        end
        n_cmp++;
        if (p_rdata !== 8'hF0) begin
            n_err++; $display("FAIL sweep_read_data: got %h want %h", p_rdata, 8'hF0);
        end
    endtask

    task automatic test_random;
        logic [7:0]  sh_val [0:15];
        bit          sh_wr  [0:15];
        logic [3:0]  idx;
        logic [7:0]  d;
        logic [7:0]  expv;
        bit          wr;
        bit          done;
        for (int i = 0; i < 16; i++) sh_wr[i] = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            wr   = 1'($urandom_range(0, 1));
            idx  = 4'($urandom_range(0, 15));
            d    = 8'($urandom_range(0, 255));
            expv = sh_wr[idx] ? sh_val[idx] : init_val({12'h004, idx});
            req_valid = 1'b1; req_write = wr; req_addr = {12'h004, idx}; req_wdata = d;
            tick();
            req_valid = 1'b0;
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                tick();
                if (rsp_valid === 1'b1) done = 1'b1;
            end
            if (!done) begin
                n_cmp++; n_err++;
                $display("FAIL random_timeout[%0d]: got no rsp_valid want rsp_valid within 20 cycles", k);
                break;
            end
            if (wr) begin
                sh_val[idx] = d;
                sh_wr[idx]  = 1'b1;
            end else begin
                n_cmp++;
                if (rsp_rdata !== expv) begin
                    n_err++; $display("FAIL random_read[%0d] addr %h: got %h want %h", k, {12'h004, idx}, rsp_rdata, expv);
                end
            end
        end
    endtask

    task automatic test_invariants;
        n_cmp++;
        if (n_viol !== 0) begin
            n_err++; $display("FAIL strobe_invariants: got %0d violations want %0d", n_viol, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_write();
        test_param_sweep();
        test_random();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
